// File: rtl/data_mem_sync.sv
// Clocked single-port word memory for the MEM stage: valid/ready requests, per-byte writes,
// a 1-cycle registered read, a hardware zero sweep after reset or on request, and address range errors.
module data_mem_sync #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmReq,
  input  logic              dmWrite,
  input  logic [ADDR_W-1:0] dmAddr,
  input  logic [DATA_W-1:0] dmWrDat,
  input  logic [BE_W-1:0]   dmBe,
  input  logic              dmClear,
  output logic              dmReady,
  output logic [DATA_W-1:0] dmReDat,
  output logic              dmReValid,
  output logic              dmErr,
  output logic              initDone
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The pointer is one bit wider than the address so a full-size memory finishes its sweep without wrapping.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W:0]   initPtr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic             accept_s;
  logic             inRange_s;
  logic             wrEn_s;
  logic [IDX_W-1:0] reqIdx_s;
  logic [IDX_W-1:0] initIdx_s;

  // A clear request closes the door in the same cycle, so a simultaneous request is never taken.
  assign dmReady = (state_r == READY) && !dmClear;

  // Request decode: acceptance, unsigned range check and array indices.
  always_comb begin
    accept_s  = dmReq && dmReady;
    inRange_s = ({1'b0, dmAddr} < DEPTH_C);
    wrEn_s    = accept_s && dmWrite && inRange_s;
    reqIdx_s  = dmAddr[IDX_W-1:0];
    initIdx_s = initPtr_r[IDX_W-1:0];
  end

  // Storage: the zero sweep owns the array in INIT, byte-masked writes in READY.
  always_ff @(posedge clk) begin
    if (state_r == INIT) begin
      mem_r[initIdx_s] <= '0;
    end else if (wrEn_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (dmBe[i]) begin
          mem_r[reqIdx_s][8*i +: 8] <= dmWrDat[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered response pulses and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= INIT;
      initPtr_r <= '0;
      initDone  <= 1'b0;
      dmReValid <= 1'b0;
      dmErr     <= 1'b0;
      dmReDat   <= '0;
    end else begin
      dmReValid <= 1'b0;
      dmErr     <= 1'b0;
      case (state_r)
        INIT: begin
          initPtr_r <= initPtr_r + PTR_ONE;
          if (initPtr_r == LAST_PTR) begin
            state_r  <= READY;
            initDone <= 1'b1;
          end
        end
        READY: begin
          if (dmClear) begin
            state_r   <= INIT;
            initPtr_r <= '0;
            initDone  <= 1'b0;
          end else if (accept_s) begin
            dmErr <= !inRange_s;
            if (!dmWrite) begin
              dmReValid <= 1'b1;
              dmReDat   <= inRange_s ? mem_r[reqIdx_s] : '0;
            end
          end
        end
        default: begin
          state_r   <= INIT;
          initPtr_r <= '0;
          initDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_sync.sv
// Scoreboard bench for data_mem_sync: a default-size instance and a DEPTH=1000 instance share
// one stimulus stream; a reference model queues expected responses and a monitor checks them.
module tb_data_mem_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmReq = 1'b0;
  logic        dmWrite = 1'b0;
  logic [9:0]  dmAddr = 10'd0;
  logic [15:0] dmWrDat = 16'd0;
  logic [1:0]  dmBe = 2'd0;
  logic        dmClear = 1'b0;

  logic        rdyA, valA, errA, doneA;
  logic [15:0] datA;
  logic        rdyB, valB, errB, doneB;
  logic [15:0] datB;

  data_mem_sync dutA (
    .clk(clk), .rst_n(rst_n), .dmReq(dmReq), .dmWrite(dmWrite), .dmAddr(dmAddr),
    .dmWrDat(dmWrDat), .dmBe(dmBe), .dmClear(dmClear), .dmReady(rdyA),
    .dmReDat(datA), .dmReValid(valA), .dmErr(errA), .initDone(doneA)
  );

  data_mem_sync #(.DEPTH(1000)) dutB (
    .clk(clk), .rst_n(rst_n), .dmReq(dmReq), .dmWrite(dmWrite), .dmAddr(dmAddr),
    .dmWrDat(dmWrDat), .dmBe(dmBe), .dmClear(dmClear), .dmReady(rdyB),
    .dmReDat(datB), .dmReValid(valB), .dmErr(errB), .initDone(doneB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          isRead;
    bit          err;
    logic [15:0] data;
  } exp_t;

  exp_t        qA[$];
  exp_t        qB[$];
  logic [15:0] mdl [2][1024];
  int          dep [2] = '{1024, 1000};
  int          left [2] = '{1024, 1000};
  logic [15:0] expLast [2] = '{16'h0, 16'h0};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int id, input exp_t e);
    if (id == 0) qA.push_back(e);
    else         qB.push_back(e);
  endtask

  // Reference behaviour for one memory for the edge that just happened.
  task automatic modelStep(input int id);
    exp_t        e;
    bit          inR;
    logic [15:0] mask;
    if (left[id] > 0) begin
      left[id]--;
    end else if (dmClear) begin
      left[id] = dep[id];
      for (int a = 0; a < 1024; a++) mdl[id][a] = 16'h0;
    end else if (dmReq) begin
      inR  = int'(dmAddr) < dep[id];
      mask = {{8{dmBe[1]}}, {8{dmBe[0]}}};
      e.due = cyc;
      if (dmWrite) begin
        if (inR) mdl[id][dmAddr] = (mdl[id][dmAddr] & ~mask) | (dmWrDat & mask);
        else begin
          e.isRead = 1'b0; e.err = 1'b1; e.data = 16'h0;
          push(id, e);
        end
      end else begin
        e.isRead = 1'b1; e.err = !inR; e.data = inR ? mdl[id][dmAddr] : 16'h0;
        push(id, e);
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left[0] = 1024;
      left[1] = 1000;
      qA.delete();
      qB.delete();
      for (int a = 0; a < 1024; a++) begin
        mdl[0][a] = 16'h0;
        mdl[1][a] = 16'h0;
      end
    end else begin
      cyc++;
      modelStep(0);
      modelStep(1);
    end
  end

  task automatic checkOne(input int id, input logic rdy, input logic done, input logic val,
                          input logic err, input logic [15:0] dat);
    exp_t  e;
    bit    have;
    string tag;
    logic  expDone, expRdy, expVal, expErr;
    tag  = (id == 0) ? "A" : "B";
    have = 1'b0;
    if (!rst_n) expLast[id] = 16'h0;
    expDone = rst_n && (left[id] == 0);
    expRdy  = expDone && !dmClear;
    if (id == 0) begin
      if (qA.size() > 0 && qA[0].due < cyc) begin
        chk({tag, " responseDue"}, qA[0].due, cyc);
        void'(qA.pop_front());
      end
      if (qA.size() > 0 && qA[0].due == cyc) begin e = qA.pop_front(); have = 1'b1; end
    end else begin
      if (qB.size() > 0 && qB[0].due < cyc) begin
        chk({tag, " responseDue"}, qB[0].due, cyc);
        void'(qB.pop_front());
      end
      if (qB.size() > 0 && qB[0].due == cyc) begin e = qB.pop_front(); have = 1'b1; end
    end
    expVal = have && e.isRead;
    expErr = have && e.err;
    if (expVal) expLast[id] = e.data;
    chk({tag, " dmReady"}, rdy, expRdy);
    chk({tag, " initDone"}, done, expDone);
    chk({tag, " dmReValid"}, val, expVal);
    chk({tag, " dmErr"}, err, expErr);
    chk({tag, " dmReDat"}, dat, expLast[id]);
  endtask

  always @(negedge clk) begin
    checkOne(0, rdyA, doneA, valA, errA, datA);
    checkOne(1, rdyB, doneB, valB, errB, datB);
  end

  task automatic drive(input logic req, input logic wr, input logic [9:0] a,
                       input logic [15:0] d, input logic [1:0] be, input logic clr);
    @(posedge clk);
    #1;
    dmReq = req; dmWrite = wr; dmAddr = a; dmWrDat = d; dmBe = be; dmClear = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 10'd0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic setRandom();
    dmReq   = ($urandom_range(0, 9) < 7);
    dmWrite = 1'($urandom_range(0, 1));
    dmAddr  = ($urandom_range(0, 3) == 0) ? 10'(990 + $urandom_range(0, 33))
                                          : 10'($urandom_range(0, 15));
    dmWrDat = 16'($urandom);
    dmBe    = 2'($urandom_range(0, 3));
    dmClear = 1'b0;
  endtask

  // Counts edges until each instance raises initDone; optional INIT-time request noise.
  task automatic waitSweep(input bit noisy, input int off);
    int gotA, gotB;
    gotA = -1;
    gotB = -1;
    for (int n = 1; n <= 2500 && (gotA < 0 || gotB < 0); n++) begin
      @(posedge clk);
      #1;
      if (doneA && gotA < 0) gotA = n;
      if (doneB && gotB < 0) gotB = n;
      if (noisy && n < 60) begin
        setRandom();
        dmClear = 1'($urandom_range(0, 1));
      end else begin
        dmReq = 1'b0; dmClear = 1'b0;
      end
    end
    chk("sweep length A", gotA, 1024 + off);
    chk("sweep length B", gotB, 1000 + off);
  endtask

  task automatic resetZeroChk();
    chk("async reset dmReady A", rdyA, 1'b0);
    chk("async reset dmReDat A", datA, 16'h0);
    chk("async reset initDone A", doneA, 1'b0);
    chk("async reset dmReValid A", valA, 1'b0);
    chk("async reset dmReady B", rdyB, 1'b0);
    chk("async reset dmReDat B", datB, 16'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    waitSweep(1'b1, 0);

    drive(1'b1, 1'b0, 10'h3FF, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 10'd5, 16'h12AB, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 10'd5, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 10'd5, 16'hFF00, 2'b01, 1'b0);
    drive(1'b1, 1'b0, 10'd5, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 10'd1000, 16'hBEEF, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 10'd1000, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 10'd999, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 10'd1, 16'h1111, 2'b11, 1'b0);
    drive(1'b1, 1'b1, 10'd2, 16'h2222, 2'b11, 1'b0);
    drive(1'b1, 1'b1, 10'd3, 16'h3333, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 10'd1, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 10'd2, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 10'd3, 16'h0, 2'b00, 1'b0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1 setRandom();
    end
    idle(2);

    drive(1'b1, 1'b1, 10'd7, 16'h5555, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 10'd7, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 10'd7, 16'hAAAA, 2'b11, 1'b1);
    waitSweep(1'b0, 1);
    drive(1'b1, 1'b0, 10'd7, 16'h0, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 10'd5, 16'h6789, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 10'd5, 16'h0, 2'b00, 1'b0);
    idle(1);

    // Read presented, then reset lands before its accepting edge.
    drive(1'b1, 1'b0, 10'd5, 16'h0, 2'b00, 1'b0);
    #1 rst_n = 1'b0;
    #1 resetZeroChk();
    dmReq = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitSweep(1'b0, 0);
    drive(1'b1, 1'b0, 10'd5, 16'h0, 2'b00, 1'b0);
    idle(1);

    // Reset in the middle of the sweep restarts it from zero.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 resetZeroChk();
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitSweep(1'b0, 0);
    drive(1'b1, 1'b0, 10'h3FF, 16'h0, 2'b00, 1'b0);
    idle(3);

    chk("pending responses A", qA.size(), 0);
    chk("pending responses B", qB.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_sync.md
Name: data_mem_sync

Overview:
- Clocked, parametrised successor to the processor's combinational data memory.
- Single-port word memory with a valid/ready request interface, per-byte write enables and a registered 1-cycle read.
- Includes a hardware zero-initialisation sweep after reset or on command, and out-of-range address detection.
- Sits between the processor's MEM stage and the data store.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- BE_W, DATA_W/8, derived byte-lane count; not to be overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dmReq  input  1  request valid.
- dmWrite  input  1  1 = write, 0 = read; sampled with dmReq.
- dmAddr  input  ADDR_W  word address.
- dmWrDat  input  DATA_W  write data.
- dmBe  input  BE_W  byte-lane write enables; bit i covers dmWrDat[8i+7:8i].
- dmClear  input  1  synchronous request to re-zero the whole memory.
- dmReady  output  1  block can accept a request this cycle.
- dmReDat  output  DATA_W  read data, registered.
- dmReValid  output  1  one-cycle pulse; dmReDat is valid.
- dmErr  output  1  one-cycle pulse; the accepted request addressed a word >= DEPTH.
- initDone  output  1  high once a zero sweep has completed.

Behaviour:
- Reset (asynchronous assertion, synchronous release): state=INIT, initPtr=0. dmReady=0, dmReValid=0, dmErr=0, dmReDat=0, initDone=0. The memory array itself is not reset.
- States: INIT, READY.
- INIT:
  - Each cycle writes 0 to DM[initPtr], then initPtr increments.
  - The cycle that writes DEPTH-1 transitions to READY. initDone goes to 1 in the same edge.
  - The sweep takes exactly DEPTH cycles after rst_n rises.
  - dmReady=0. dmReq is ignored; no response is generated.
- READY:
  - dmReady=1 combinationally when state==READY. Accept = dmReq & dmReady.
  - dmClear=1 in READY: next state INIT, initPtr=0, initDone=0. dmClear has priority over a same-cycle dmReq; that request is not accepted (dmReady is 0 that cycle). dmClear is ignored while in INIT.
- Accepted write, dmAddr < DEPTH: at the same edge, each lane i with dmBe[i]=1 takes dmWrDat lane i; other lanes keep their value. dmBe=0 is a legal no-op. No dmReValid.
- Accepted read, dmAddr < DEPTH: at the next edge, dmReDat=DM[dmAddr] and dmReValid=1 for one cycle (latency 1). Back-to-back reads are allowed every cycle.
- Write then read of the same address on consecutive cycles returns the new data.
- Accepted request with dmAddr >= DEPTH:
  - Write: memory is unchanged.
  - Read: dmReDat=0 and dmReValid=1.
  - dmErr=1 for one cycle, aligned with the response cycle (edge after acceptance).
- dmReDat holds its last value when dmReValid=0. dmErr and dmReValid are 0 in all other cycles.
- Reset asserted mid-INIT or mid-operation: outputs go to reset values immediately. A pending read response is discarded. The sweep restarts from 0 after release.
- Arithmetic: initPtr is ADDR_W+1 bits wide, so DEPTH=2**ADDR_W terminates without wrap. Address compare is unsigned.

Test Plan:
- Reset release, DEPTH=1024: dmReady=0 and initDone=0 for cycles 0..1023; both are 1 from cycle 1024. A read of 0x3FF then returns 0x0000 with dmReValid one cycle after acceptance.
- Write 0x12AB to address 5 with dmBe=2'b11, then write 0xFF00 with dmBe=2'b01, then read 5 -> 0x1200 on the cycle after read acceptance. Read on the cycle right after the first write returns 0x12AB.
- DEPTH=1000 override: write 0xBEEF to 1000 and read 1000 -> dmErr pulses once per request, read data 0x0000 with dmReValid=1. A read of 999 is unaffected and dmErr=0.
- Reads of 1, 2, 3 issued on three consecutive cycles -> three consecutive dmReValid pulses with data in order. dmReq asserted during INIT -> no dmReValid and no memory change.
- dmClear asserted together with a write to address 7 (previously 0x5555) -> write is not accepted, dmReady drops. After 1024 cycles initDone=1 and a read of 7 returns 0x0000.
- rst_n pulsed low at sweep cycle 300 -> outputs zero immediately, sweep restarts, initDone rises 1024 cycles after release. A read issued the cycle before reset produces no dmReValid.
